hamming32t26d_scrub_ctrl: RTL and testbench

Single-port controller for a SECDED-protected word memory holding 32-bit Hamming codewords (26 data bits, 5 Hamming bits, 1 overall parity bit).

- Host side: encodes host writes and returns corrected data on host reads.
- Scrub side: a background engine walks every address, corrects single-bit errors in place and counts single/double errors.
- Placement: between the bus-side register/memory interface and a synchronous single-port SRAM, in the SafeSU protected-storage path.

---
 rtl/hamming_pkg.sv | 25 ++
 rtl/hamming32t26d_dec.sv | 40 ++++
 rtl/hamming32t26d_enc.sv | 20 ++
 rtl/hamming32t26d_scrub_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hamming32t26d_scrub_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared types and codeword layout for the 32-bit (26 data + 5 Hamming + overall
// parity) SECDED codeword used by the scrub controller.
package hamming_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_READ, ST_CHECK, ST_WB, ST_ADVANCE
    } scrub_state_e;

    typedef enum logic [1:0] {
        DEC_CLEAN, DEC_SINGLE, DEC_DOUBLE
    } dec_status_e;

    localparam int CW_W    = 32;
    localparam int DATA_W  = 26;
    localparam int NUM_CHK = 5;

    localparam int CHK_POS [NUM_CHK] = '{1, 2, 4, 8, 16};

    // Data bit i lives at codeword position DATA_POS[i]
    localparam int DATA_POS [DATA_W] = '{
        3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15,
        17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31
    };

endpackage

// File: rtl/hamming32t26d_dec.sv
// Combinational SECDED decode: syndrome + overall parity, single-bit correction,
// data extraction and clean/single/double classification.
module hamming32t26d_dec
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   i_cw,
    output logic [CW_W-1:0]   o_cw,
    output logic [DATA_W-1:0] o_data,
    output dec_status_e       o_status
);

    logic [NUM_CHK-1:0] w_syn;
    logic               w_par;

    always_comb begin
        w_syn = '0;
        for (int j = 1; j < CW_W; j++)
            for (int k = 0; k < NUM_CHK; k++)
                if (((j >> k) & 1) == 1)
                    w_syn[k] = w_syn[k] ^ i_cw[j];
        w_par = ^i_cw;

        // Odd parity means one flip; syndrome 0 then points at the parity bit itself
        o_cw = i_cw;
        if (w_par)
            o_cw[w_syn] = ~i_cw[w_syn];

        o_data = '0;
        for (int i = 0; i < DATA_W; i++)
            o_data[i] = o_cw[DATA_POS[i]];

        if (w_par)
            o_status = DEC_SINGLE;
        else if (w_syn != '0)
            o_status = DEC_DOUBLE;
        else
            o_status = DEC_CLEAN;
    end

endmodule

// File: rtl/hamming32t26d_enc.sv
// 26-bit data to 32-bit SECDED codeword encoder (purely combinational).
module hamming32t26d_enc
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CW_W-1:0]   o_cw
);

    always_comb begin
        o_cw = '0;
        for (int i = 0; i < DATA_W; i++)
            o_cw[DATA_POS[i]] = i_data[i];
        for (int k = 0; k < NUM_CHK; k++)
            for (int j = 3; j < CW_W; j++)
                if (((j >> k) & 1) == 1 && j != CHK_POS[k])
                    o_cw[CHK_POS[k]] = o_cw[CHK_POS[k]] ^ o_cw[j];
        o_cw[0] = ^o_cw[CW_W-1:1];
    end

endmodule

// File: rtl/hamming32t26d_scrub_ctrl.sv
// SECDED memory controller: host read/write path plus background scrubber.
// Error counters are built only when HAMMING_SCRUB_CNT_EN is defined.
module hamming32t26d_scrub_ctrl
    import hamming_pkg::*;
#(
    parameter  int DEPTH = 256,
    parameter  int CNT_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              scrub_en_i,
    input  logic [15:0]       period_i,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [AW-1:0]     host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic              host_rvalid_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_uerr_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [CW_W-1:0]   mem_wdata_o,
    input  logic [CW_W-1:0]   mem_rdata_i,
    input  logic              clr_cnt_i,
    output logic [CNT_W-1:0]  cnt_corr_o,
    output logic [CNT_W-1:0]  cnt_uncorr_o,
    output logic [AW-1:0]     scrub_addr_o
);

    scrub_state_e      r_state, w_next;
    logic [15:0]       r_timer;
    logic [AW-1:0]     r_scrub_addr;
    logic              r_rd_pend;
    logic [CW_W-1:0]   r_wb_cw;
    logic              w_gnt, w_wr_hit, w_reload;
    logic [CW_W-1:0]   w_enc_cw, w_dec_cw;
    logic [DATA_W-1:0] w_dec_data;
    dec_status_e       w_dec_st;

    hamming32t26d_enc u_enc (.i_data(host_wdata_i), .o_cw(w_enc_cw));

    // One decoder serves both paths: the single port means only one read returns per cycle
    hamming32t26d_dec u_dec (
        .i_cw(mem_rdata_i), .o_cw(w_dec_cw), .o_data(w_dec_data), .o_status(w_dec_st)
    );

    assign w_gnt    = host_req_i & ~rst_i & (r_state != ST_READ) & (r_state != ST_WB);
    assign w_wr_hit = w_gnt & host_we_i & (host_addr_i == r_scrub_addr);
    assign w_reload = (w_next == ST_WAIT) & (r_state != ST_WAIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (scrub_en_i) w_next = ST_WAIT;
            ST_WAIT: begin
                if (!scrub_en_i)
                    w_next = ST_IDLE;
                else if (r_timer == '0 && !host_req_i)
                    w_next = ST_READ;
            end
            ST_READ:    w_next = ST_CHECK;
            ST_CHECK:   w_next = (w_dec_st == DEC_SINGLE && !w_wr_hit) ? ST_WB : ST_ADVANCE;
            ST_WB:      w_next = ST_ADVANCE;
            ST_ADVANCE: w_next = scrub_en_i ? ST_WAIT : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timer      <= '0;
            r_scrub_addr <= '0;
            r_rd_pend    <= 1'b0;
            r_wb_cw      <= '0;
        end else begin
            r_rd_pend <= w_gnt & ~host_we_i;
            if (w_reload)
                r_timer <= period_i;
            else if (r_state == ST_WAIT && r_timer != '0)
                r_timer <= r_timer - 16'd1;
            if (r_state == ST_CHECK)
                r_wb_cw <= w_dec_cw;
            if (r_state == ST_ADVANCE)
                r_scrub_addr <= (r_scrub_addr == AW'(DEPTH - 1)) ? '0 : r_scrub_addr + 1'b1;
        end
    end

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (r_state)
            ST_READ: begin
                mem_en_o   = 1'b1;
                mem_addr_o = r_scrub_addr;
            end
            ST_WB: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_scrub_addr;
                mem_wdata_o = r_wb_cw;
            end
            default: begin
                if (w_gnt) begin
                    mem_en_o   = 1'b1;
                    mem_we_o   = host_we_i;
                    mem_addr_o = host_addr_i;
                    if (host_we_i)
                        mem_wdata_o = w_enc_cw;
                end
            end
        endcase
    end

    assign host_gnt_o    = w_gnt;
    assign host_rvalid_o = r_rd_pend;
    assign host_rdata_o  = r_rd_pend ? w_dec_data : '0;
    assign host_uerr_o   = r_rd_pend & (w_dec_st == DEC_DOUBLE);
    assign scrub_addr_o  = r_scrub_addr;

`ifdef HAMMING_SCRUB_CNT_EN
    logic [CNT_W-1:0] r_cnt_corr, r_cnt_uncorr;
    logic             w_inc_corr, w_inc_uncorr;

    // Host-read singles count too; host reads and scrub checks are never in the same cycle
    assign w_inc_corr   = (w_dec_st == DEC_SINGLE) & ((r_state == ST_CHECK) | r_rd_pend);
    assign w_inc_uncorr = (w_dec_st == DEC_DOUBLE) & (r_state == ST_CHECK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (clr_cnt_i) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else begin
            if (w_inc_corr && !(&r_cnt_corr))
                r_cnt_corr <= r_cnt_corr + 1'b1;
            if (w_inc_uncorr && !(&r_cnt_uncorr))
                r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
        end
    end

    assign cnt_corr_o   = r_cnt_corr;
    assign cnt_uncorr_o = r_cnt_uncorr;
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_cnt_i;
    assign cnt_corr_o   = '0;
    assign cnt_uncorr_o = '0;
`endif

endmodule

// File: tb/tb_hamming32t26d_scrub_ctrl.sv
// Self-checking bench: SRAM model, spec-level reference model checked every cycle,
// directed scenarios followed by randomized host traffic and error injection.
module tb_hamming32t26d_scrub_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int AW    = 2;
    localparam int CMAX  = 3;
    localparam int P_IDLE = 0, P_WAIT = 1, P_READ = 2, P_CHECK = 3, P_WB = 4, P_ADV = 5;
`ifdef HAMMING_SCRUB_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic scrub_en = 1'b0, host_req = 1'b0, host_we = 1'b0, clr_cnt = 1'b0;
    logic [15:0] period = '0;
    logic [AW-1:0] host_addr = '0;
    logic [25:0] host_wdata = '0;
    logic host_gnt, host_rvalid, host_uerr, mem_en, mem_we;
    logic [25:0] host_rdata;
    logic [AW-1:0] mem_addr, scrub_addr;
    logic [31:0] mem_wdata, rdata_q;
    logic [CNT_W-1:0] cnt_corr, cnt_uncorr;

    always #5 clk = ~clk;

    hamming32t26d_scrub_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .scrub_en_i(scrub_en), .period_i(period),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
        .host_rdata_o(host_rdata), .host_uerr_o(host_uerr), .mem_en_o(mem_en),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(rdata_q), .clr_cnt_i(clr_cnt), .cnt_corr_o(cnt_corr),
        .cnt_uncorr_o(cnt_uncorr), .scrub_addr_o(scrub_addr)
    );

    // SRAM with a backdoor bit-flip port
    logic [31:0] mem [DEPTH];
    logic inj = 1'b0;
    logic [AW-1:0] inj_addr = '0;
    logic [31:0] inj_mask = '0;
    initial rdata_q = '0;
    always @(posedge clk) begin
        if (mem_en && !mem_we) rdata_q <= mem[mem_addr];
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        if (inj) mem[inj_addr] = mem[inj_addr] ^ inj_mask;
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Check bits = XOR of the indices of all set data positions
    function automatic logic [31:0] ref_enc(input logic [25:0] d);
        logic [31:0] cw = '0;
        int di = 0, syn = 0;
        for (int pos = 1; pos < 32; pos++)
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                if (d[di]) syn = syn ^ pos;
                di++;
            end
        for (int k = 0; k < 5; k++) cw[1 << k] = syn[k];
        cw[0] = ^cw[31:1];
        return cw;
    endfunction

    function automatic void ref_dec(input logic [31:0] cw, output int st,
                                    output logic [31:0] cc, output logic [25:0] d);
        int syn = 0, di = 0;
        for (int pos = 1; pos < 32; pos++) if (cw[pos]) syn = syn ^ pos;
        cc = cw;
        if (^cw) begin st = 1; cc[syn] = ~cc[syn]; end
        else if (syn != 0) st = 2;
        else st = 0;
        d = '0;
        for (int pos = 1; pos < 32; pos++)
            if ((pos & (pos - 1)) != 0) begin d[di] = cc[pos]; di++; end
    endfunction

    // Reference model state (describes the current cycle after each negedge update)
    int m_phase = P_IDLE, m_timer = 0, m_saddr = 0, m_corr = 0, m_uncorr = 0;
    bit m_rdpend = 1'b0;
    logic [31:0] m_wbcw = '0;

    int c_st;
    logic [31:0] c_cc;
    logic [25:0] c_dd;
    bit c_busy, c_gnt, c_en, c_we, c_ic, c_iu;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_gnt", 32'(host_gnt), 0);
            chk("rst_rvalid", 32'(host_rvalid), 0);
            chk("rst_rdata", 32'(host_rdata), 0);
            chk("rst_uerr", 32'(host_uerr), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_cnt_corr", 32'(cnt_corr), 0);
            chk("rst_cnt_uncorr", 32'(cnt_uncorr), 0);
            chk("rst_scrub_addr", 32'(scrub_addr), 0);
            m_phase = P_IDLE; m_timer = 0; m_saddr = 0; m_corr = 0; m_uncorr = 0;
            m_rdpend = 1'b0; m_wbcw = '0;
        end else begin
            c_busy = (m_phase == P_READ) || (m_phase == P_WB);
            c_gnt  = host_req && !c_busy;
            c_en   = c_busy || c_gnt;
            c_we   = (m_phase == P_WB) || (m_phase != P_READ && c_gnt && host_we);
            chk("gnt", 32'(host_gnt), 32'(c_gnt));
            chk("mem_en", 32'(mem_en), 32'(c_en));
            if (c_en) begin
                chk("mem_we", 32'(mem_we), 32'(c_we));
                chk("mem_addr", 32'(mem_addr), c_busy ? 32'(m_saddr) : 32'(host_addr));
                if (c_we)
                    chk("mem_wdata", mem_wdata, (m_phase == P_WB) ? m_wbcw : ref_enc(host_wdata));
            end
            chk("rvalid", 32'(host_rvalid), 32'(m_rdpend));
            c_ic = 1'b0; c_iu = 1'b0;
            if (m_rdpend) begin
                ref_dec(rdata_q, c_st, c_cc, c_dd);
                chk("rdata", 32'(host_rdata), 32'(c_dd));
                chk("uerr", 32'(host_uerr), 32'(c_st == 2));
                if (c_st == 1) c_ic = 1'b1;
            end
            chk("scrub_addr", 32'(scrub_addr), 32'(m_saddr));
            chk("cnt_corr", 32'(cnt_corr), CNT_ON ? 32'(m_corr) : 0);
            chk("cnt_uncorr", 32'(cnt_uncorr), CNT_ON ? 32'(m_uncorr) : 0);

            m_rdpend = c_gnt && !host_we;
            case (m_phase)
                P_IDLE: if (scrub_en) begin m_phase = P_WAIT; m_timer = int'(period); end
                P_WAIT: begin
                    if (!scrub_en) m_phase = P_IDLE;
                    else if (m_timer == 0) begin if (!host_req) m_phase = P_READ; end
                    else m_timer--;
                end
                P_READ: m_phase = P_CHECK;
                P_CHECK: begin
                    ref_dec(rdata_q, c_st, c_cc, c_dd);
                    m_phase = P_ADV;
                    if (c_st == 2) c_iu = 1'b1;
                    if (c_st == 1) begin
                        c_ic = 1'b1;
                        if (!(c_gnt && host_we && int'(host_addr) == m_saddr)) begin
                            m_phase = P_WB; m_wbcw = c_cc;
                        end
                    end
                end
                P_WB: m_phase = P_ADV;
                default: begin
                    m_saddr = (m_saddr + 1) % DEPTH;
                    if (scrub_en) begin m_phase = P_WAIT; m_timer = int'(period); end
                    else m_phase = P_IDLE;
                end
            endcase
            if (clr_cnt) begin m_corr = 0; m_uncorr = 0; end
            else begin
                if (c_ic && m_corr < CMAX) m_corr++;
                if (c_iu && m_uncorr < CMAX) m_uncorr++;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic wait_saddr(input int a, input int budget, input string nm);
        int n = 0;
        while (m_saddr != a && n < budget) begin tick(); n++; end
        n_chk++;
        if (m_saddr != a) begin
            n_err++;
            $display("FAIL %s: timeout, scrub_addr %0d want %0d", nm, m_saddr, a);
        end
    endtask

    task automatic wait_phase(input int ph, input int sa, input int budget, input string nm);
        int n = 0;
        while (!(m_phase == ph && (sa < 0 || m_saddr == sa)) && n < budget) begin tick(); n++; end
        n_chk++;
        if (!(m_phase == ph && (sa < 0 || m_saddr == sa))) begin
            n_err++;
            $display("FAIL %s: timeout, phase %0d want %0d", nm, m_phase, ph);
        end
    endtask

    task automatic flip(input int a, input logic [31:0] mask);
        inj = 1'b1; inj_addr = AW'(a); inj_mask = mask;
        tick();
        inj = 1'b0;
    endtask

    task automatic host_read(input int a);
        while (m_phase == P_READ || m_phase == P_WB) tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = AW'(a);
        tick();
        host_req = 1'b0;
    endtask

    logic [25:0] gold [DEPTH];
    int p_st;
    logic [31:0] p_cc;
    logic [25:0] p_dd;

    initial begin
        // Pin the reference model with hand-computed codewords
        chk("pin_enc_ones", ref_enc(26'h3FFFFFF), 32'hFFFFFFFF);
        chk("pin_enc_one", ref_enc(26'h0000001), 32'h0000000F);
        chk("pin_enc_15", ref_enc(26'h0000015), 32'h00000359);
        ref_dec(32'hFFFFFF7F, p_st, p_cc, p_dd);
        chk("pin_dec_single_st", 32'(p_st), 1);
        chk("pin_dec_single_cw", p_cc, 32'hFFFFFFFF);
        ref_dec(32'h00000359 ^ 32'h00000028, p_st, p_cc, p_dd);
        chk("pin_dec_double_st", 32'(p_st), 2);

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Clean round trip and memory initialisation
        for (int a = 0; a < DEPTH; a++) gold[a] = 26'($urandom);
        gold[1] = 26'h3FFFFFF;
        for (int a = 0; a < DEPTH; a++) begin
            host_req = 1'b1; host_we = 1'b1; host_addr = AW'(a); host_wdata = gold[a];
            tick();
        end
        host_req = 1'b0; host_we = 1'b0;
        tick();
        chk("mem1_literal", mem[1], 32'hFFFFFFFF);
        host_read(1);
        chk("rd_valid_lit", 32'(host_rvalid), 1);
        chk("rd_data_lit", 32'(host_rdata), 32'h03FFFFFF);
        chk("rd_uerr_lit", 32'(host_uerr), 0);
        tick();
        chk("rd_valid_drop", 32'(host_rvalid), 0);

        // Scrub repairs a single-bit error at addr 2
        flip(2, 32'h00000080);
        scrub_en = 1'b1; period = 16'd3;
        wait_saddr(3, 80, "wait_repair");
        chk("repair_mem2", mem[2], ref_enc(gold[2]));
        chk("repair_cnt", 32'(cnt_corr), CNT_ON ? 1 : 0);

        // Double error at addr 0 is counted and left alone
        flip(0, 32'h00000028);
        wait_saddr(1, 80, "wait_double");
        chk("double_mem0", mem[0], ref_enc(gold[0]) ^ 32'h00000028);
        chk("double_cnt", 32'(cnt_uncorr), CNT_ON ? 1 : 0);
        host_read(0);
        chk("double_uerr_lit", 32'(host_uerr), 1);

        // Host write in the CHECK cycle cancels the writeback
        wait_saddr(2, 80, "wait_pre_cancel");
        flip(1, 32'h00000400);
        wait_phase(P_CHECK, 1, 120, "wait_check1");
        host_req = 1'b1; host_we = 1'b1; host_addr = 2'd1; host_wdata = 26'h0000015;
        tick();
        host_req = 1'b0; host_we = 1'b0;
        wait_saddr(2, 80, "wait_post_cancel");
        chk("cancel_mem1", mem[1], 32'h00000359);

        // Continuous host traffic starves the scrubber
        wait_phase(P_WAIT, -1, 40, "wait_for_wait");
        host_req = 1'b1; host_we = 1'b0;
        for (int i = 0; i < 30; i++) begin host_addr = AW'($urandom_range(0, 3)); tick(); end
        chk("starve_phase", 32'(m_phase), P_WAIT);
        host_req = 1'b0;

        // Randomised traffic, injections, clears and enable toggles
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) scrub_en = ~scrub_en;
            period     = 16'($urandom_range(0, 3));
            host_req   = ($urandom_range(0, 2) == 0);
            host_we    = $urandom_range(0, 1) == 1;
            host_addr  = AW'($urandom_range(0, 3));
            host_wdata = 26'($urandom);
            clr_cnt    = ($urandom_range(0, 39) == 0);
            inj        = ($urandom_range(0, 19) == 0);
            inj_addr   = AW'($urandom_range(0, 3));
            inj_mask   = 32'(1) << $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) inj_mask = inj_mask | (32'(1) << $urandom_range(0, 31));
            tick();
        end
        host_req = 1'b0; clr_cnt = 1'b0; inj = 1'b0;

        // Reset asserted during a writeback
        for (int a = 0; a < DEPTH; a++) begin
            host_req = 1'b1; host_we = 1'b1; host_addr = AW'(a); host_wdata = 26'($urandom);
            while (m_phase == P_READ || m_phase == P_WB) tick();
            tick();
        end
        host_req = 1'b0; host_we = 1'b0;
        for (int a = 0; a < DEPTH; a++) flip(a, 32'h00010000);
        scrub_en = 1'b1; period = 16'd0;
        wait_phase(P_WB, -1, 100, "wait_wb");
        chk("pre_rst_mem_we", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        chk("async_mem_en", 32'(mem_en), 0);
        chk("async_mem_we", 32'(mem_we), 0);
        chk("async_scrub_addr", 32'(scrub_addr), 0);
        tick(); tick();
        scrub_en = 1'b0;
        rst = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
